pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_stage_reg.sv | 110 +++++++++++
 tb/tb_pipe_stage_reg.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared state encoding and occupancy helpers for pipe_stage_reg.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   localparam int unsigned OCC_W = 2;

   function automatic logic [OCC_W-1:0] occ_of(input state_e s);
      case (s)
         ST_HALF: occ_of = 2'd1;
         ST_FULL: occ_of = 2'd2;
         default: occ_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register stage with optional skid buffer.
// Define PIPE_STAGE_REG_SKID_EN for the two-entry skid variant with registered readyIn.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             CLK,
   input  logic             resetN,
   input  logic [WIDTH-1:0] dataIn,
   input  logic             validIn,
   output logic             readyIn,
   output logic [WIDTH-1:0] dataOut,
   output logic             validOut,
   input  logic             readyOut,
   input  logic             flush,
   output logic [OCC_W-1:0] occupancy
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic             valid_q;
   logic [OCC_W-1:0] occ_q;
`ifdef PIPE_STAGE_REG_SKID_EN
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             rdy_q;
`endif

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_d  = skid_q;
`endif
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (validIn) begin
                  main_d  = dataIn;
                  state_d = ST_HALF;
               end
            end
            ST_HALF: begin
`ifdef PIPE_STAGE_REG_SKID_EN
               if (validIn && readyOut) begin
                  main_d = dataIn;
               end else if (validIn) begin
                  skid_d  = dataIn;
                  state_d = ST_FULL;
               end else if (readyOut) begin
                  state_d = ST_EMPTY;
               end
`else
               // Without a skid slot a stalled word blocks upstream entirely.
               if (readyOut) begin
                  if (validIn) main_d = dataIn;
                  else         state_d = ST_EMPTY;
               end
`endif
            end
`ifdef PIPE_STAGE_REG_SKID_EN
            ST_FULL: begin
               if (readyOut) begin
                  main_d  = skid_q;
                  state_d = ST_HALF;
               end
            end
`endif
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Status outputs are registered from the next state so they never
   // depend combinationally on downstream ready.
   always_ff @(posedge CLK) begin
      if (!resetN) begin
         state_q <= ST_EMPTY;
         main_q  <= RESET_VAL;
         valid_q <= 1'b0;
         occ_q   <= '0;
`ifdef PIPE_STAGE_REG_SKID_EN
         skid_q  <= RESET_VAL;
         rdy_q   <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         valid_q <= (state_d != ST_EMPTY);
         occ_q   <= occ_of(state_d);
`ifdef PIPE_STAGE_REG_SKID_EN
         skid_q  <= skid_d;
         rdy_q   <= (state_d != ST_FULL);
`endif
      end
   end

   assign dataOut   = main_q;
   assign validOut  = valid_q;
   assign occupancy = occ_q;
`ifdef PIPE_STAGE_REG_SKID_EN
   assign readyIn   = rdy_q;
`else
   assign readyIn   = !valid_q || readyOut;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle plus directed literals.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int unsigned      W    = 32;
   localparam logic [W-1:0]     RVAL = 32'hDEAD_BEEF;
`ifdef PIPE_STAGE_REG_SKID_EN
   localparam int unsigned      CAP  = 2;
`else
   localparam int unsigned      CAP  = 1;
`endif

   logic             CLK = 1'b0;
   logic             resetN, validIn, readyOut, flush, readyIn, validOut;
   logic [W-1:0]     dataIn, dataOut;
   logic [OCC_W-1:0] occupancy;

   int n_cmp = 0;
   int n_bad = 0;

   pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
      .CLK(CLK), .resetN(resetN), .dataIn(dataIn), .validIn(validIn),
      .readyIn(readyIn), .dataOut(dataOut), .validOut(validOut),
      .readyOut(readyOut), .flush(flush), .occupancy(occupancy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: the stage is a FIFO of capacity CAP; dataOut shows its head.
   logic [W-1:0] q[$];
   bit           live  = 0;
   bit           known = 0;
   logic [W-1:0] m_dout;
   bit           m_rdy;

   function automatic bit model_ready();
      if (CAP == 2) return q.size() < 2;
      else          return (q.size() == 0) || readyOut;
   endfunction

   always @(posedge CLK) begin
      if (!resetN) begin
         q.delete();
         live   = 1;
         known  = 1;
         m_dout = RVAL;
      end else if (live) begin
         if (flush) begin
            q.delete();
            known = 0;
         end else begin
            m_rdy = model_ready();
            if (q.size() > 0 && readyOut) q.pop_front();
            if (validIn && m_rdy) q.push_back(dataIn);
            if (q.size() > 0) begin
               known  = 1;
               m_dout = q[0];
            end else if (!(known && m_dout == RVAL)) begin
               known = 0;
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (live) begin
         chk("model_valid", 64'(validOut), 64'(q.size() != 0));
         chk("model_occ",   64'(occupancy), 64'(q.size()));
         chk("model_ready", 64'(readyIn), 64'(model_ready()));
         if (known) chk("model_data", 64'(dataOut), 64'(m_dout));
         chk("no_x", 64'($isunknown({readyIn, validOut, dataOut, occupancy})), 64'd0);
      end
   end

   task automatic drive(input logic v, input logic [W-1:0] d, input logic ro, input logic fl);
      validIn  = v;
      dataIn   = d;
      readyOut = ro;
      flush    = fl;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      resetN = 1'b0;
      drive(1'b1, 32'h0000_0099, 1'b1, 1'b1);
      tick(); tick();
      chk("rst_valid", 64'(validOut), 64'd0);
      chk("rst_occ",   64'(occupancy), 64'd0);
      chk("rst_ready", 64'(readyIn), 64'd1);
      chk("rst_data",  64'(dataOut), 64'hDEAD_BEEF);

      resetN = 1'b1;
      drive(1'b1, 32'h0000_00A5, 1'b1, 1'b0);
      tick();
      chk("first_data",  64'(dataOut), 64'hA5);
      chk("first_valid", 64'(validOut), 64'd1);
      chk("first_occ",   64'(occupancy), 64'd1);
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      chk("drain_valid", 64'(validOut), 64'd0);

      drive(1'b1, 32'h11, 1'b0, 1'b0);
      tick();
      chk("half_data", 64'(dataOut), 64'h11);
`ifdef PIPE_STAGE_REG_SKID_EN
      drive(1'b1, 32'h22, 1'b0, 1'b0);
      tick();
      chk("full_ready", 64'(readyIn), 64'd0);
      chk("full_occ",   64'(occupancy), 64'd2);
      chk("full_data",  64'(dataOut), 64'h11);
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      chk("pop1_data", 64'(dataOut), 64'h22);
      chk("pop1_occ",  64'(occupancy), 64'd1);
      tick();
      chk("pop2_occ",  64'(occupancy), 64'd0);

      drive(1'b1, 32'h33, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h44, 1'b0, 1'b0); tick();
      chk("fill_occ", 64'(occupancy), 64'd2);
      drive(1'b1, 32'h55, 1'b1, 1'b1);
      tick();
      chk("flush_valid", 64'(validOut), 64'd0);
      chk("flush_occ",   64'(occupancy), 64'd0);
      chk("flush_ready", 64'(readyIn), 64'd1);
      drive(1'b0, '0, 1'b1, 1'b0);
      tick(); tick();
      chk("flush_gone", 64'(validOut), 64'd0);

      drive(1'b1, 32'h66, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h77, 1'b0, 1'b0); tick();
      resetN = 1'b0;
      drive(1'b1, 32'h88, 1'b1, 1'b0);
      tick();
      chk("rstfull_data",  64'(dataOut), 64'hDEAD_BEEF);
      chk("rstfull_valid", 64'(validOut), 64'd0);
      chk("rstfull_ready", 64'(readyIn), 64'd1);
      resetN = 1'b1;
`else
      drive(1'b1, 32'h22, 1'b0, 1'b0);
      #1;
      chk("stall_ready", 64'(readyIn), 64'd0);
      tick();
      chk("stall_data", 64'(dataOut), 64'h11);
      chk("stall_occ",  64'(occupancy), 64'd1);
      drive(1'b0, '0, 1'b1, 1'b1);
      tick();
      chk("flush_valid", 64'(validOut), 64'd0);
      resetN = 1'b0;
      drive(1'b1, 32'h88, 1'b1, 1'b0);
      tick();
      chk("rst2_data", 64'(dataOut), 64'hDEAD_BEEF);
      resetN = 1'b1;
`endif

      for (int unsigned i = 0; i < 1000; i++) begin
         drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
               1'($urandom_range(0, 3) != 0), 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      tick(); tick(); tick();
      chk("end_occ", 64'(occupancy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
